// File: rtl/snn_pkg.sv
// Shared types and helpers for the LIF neuron array.
// No logic state: FSM encoding, config address offsets and a saturating clamp.
// No flow control; pure definitions.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_e;

    // Special config registers sit directly above the weight block.
    function automatic int addr_thresh(input int n_w);
        return n_w;
    endfunction

    function automatic int addr_leak(input int n_w);
        return n_w + 1;
    endfunction

    function automatic int addr_clear(input int n_w);
        return n_w + 2;
    endfunction

    // Clamp v into the signed range of a w-bit two's-complement value.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/snn_lif_core_if.sv
// Configuration write bus for snn_lif_core (valid/ready, address, data).
// Latency: write lands on the edge where valid & ready are both high.
// Backpressure: slave drops ready while a timestep is running or starting.
interface snn_lif_core_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;

    modport master (output cfg_valid, cfg_addr, cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, cfg_addr, cfg_data, output cfg_ready);
endinterface

// File: rtl/snn_lif_update.sv
// Single-neuron LIF datapath: weighted spike sum, leak, saturate, fire test, post-fire value.
// Latency: purely combinational.
// Backpressure: none. Macro SNN_SOFT_RESET_EN selects subtract-threshold reset on fire.
// Ports: weights_i/spikes_i (row of synapses), mem_i/thresh_i/leak_i (state+config),
//        mem_o (next membrane), fire_o (spike).
module snn_lif_update
    import snn_pkg::*;
#(
    parameter int N_IN     = 4,
    parameter int WEIGHT_W = 4,
    parameter int MEM_W    = 8,
    parameter int LEAK_W   = 3
) (
    input  logic [WEIGHT_W-1:0]     weights_i [N_IN],
    input  logic [N_IN-1:0]         spikes_i,
    input  logic signed [MEM_W-1:0] mem_i,
    input  logic [MEM_W-2:0]        thresh_i,
    input  logic [LEAK_W-1:0]       leak_i,
    output logic signed [MEM_W-1:0] mem_o,
    output logic                    fire_o
);
    localparam int IN_W = $clog2(N_IN);

    // The sum never exceeds WEIGHT_W+$clog2(N_IN)+1 bits; carrying it in 32 bits
    // keeps every intermediate exact before the single saturation step.
    logic signed [31:0] sum;
    logic signed [31:0] mem_ext;
    logic signed [31:0] leaked;
    logic signed [31:0] nxt;
    logic signed [31:0] thr;
    logic signed [31:0] rst_val;
    logic signed [31:0] res;
    logic               unused_res_hi;

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (spikes_i[IN_W'(i)]) begin
                sum = sum + 32'($signed(weights_i[IN_W'(i)]));
            end
        end
        mem_ext = 32'(mem_i);
        leaked  = (leak_i == '0) ? mem_ext : mem_ext - (mem_ext >>> leak_i);
        nxt     = sat_signed(leaked + sum, MEM_W);
        // Threshold is unsigned; zero-extending keeps the compare signed and correct.
        thr     = 32'({1'b0, thresh_i});
        fire_o  = (nxt >= thr);
`ifdef SNN_SOFT_RESET_EN
        rst_val = sat_signed(nxt - thr, MEM_W);
`else
        rst_val = '0;
`endif
        res     = fire_o ? rst_val : nxt;
    end

    assign mem_o         = res[MEM_W-1:0];
    assign unused_res_hi = ^res[31:MEM_W];

endmodule

// File: rtl/snn_lif_core.sv
// LIF neuron array: per timestep, evaluates one neuron per cycle against a signed weight matrix.
// Latency: step accepted at edge T -> done_o in cycle T+N_NEURONS+1 with out_spikes_o valid.
// Backpressure: cfg_ready low outside IDLE and on a same-cycle step; steps while busy set overrun_o.
// Ports: wb_clk_i/wb_rst_ni (sync active-low), en_i/step_i/in_spikes_i (timestep), cfg (config bus),
//        busy_o/done_o/out_spikes_o/overrun_o (status), dbg_sel_i/mem_dbg_o (membrane peek).
// Build option: SNN_SOFT_RESET_EN (see snn_lif_update).
module snn_lif_core
    import snn_pkg::*;
#(
    parameter int N_IN           = 4,
    parameter int N_NEURONS      = 4,
    parameter int WEIGHT_W       = 4,
    parameter int MEM_W          = 8,
    parameter int THRESH_DEFAULT = 16,
    parameter int LEAK_DEFAULT   = 0
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_ni,
    input  logic                         en_i,
    input  logic                         step_i,
    input  logic [N_IN-1:0]              in_spikes_i,
    snn_lif_core_if.slave                cfg,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [N_NEURONS-1:0]         out_spikes_o,
    output logic                         overrun_o,
    input  logic [$clog2(N_NEURONS)-1:0] dbg_sel_i,
    output logic signed [MEM_W-1:0]      mem_dbg_o
);
    localparam int N_W    = N_IN * N_NEURONS;
    localparam int ADDR_W = $clog2(N_W + 3);
    localparam int IDX_W  = $clog2(N_NEURONS);
    localparam int IN_W   = $clog2(N_IN);
    localparam int LEAK_W = $clog2(MEM_W);
    localparam logic [31:0] THRESH_RST32 = THRESH_DEFAULT;
    localparam logic [31:0] LEAK_RST32   = LEAK_DEFAULT;

    state_e                   state_q;
    logic [IDX_W-1:0]         idx_q;
    logic [N_IN-1:0]          in_q;
    logic [N_NEURONS-1:0]     spk_q;
    logic [N_NEURONS-1:0]     spk_d;
    logic [N_NEURONS-1:0]     out_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     overrun_q;
    logic [MEM_W-2:0]         thresh_q;
    logic [LEAK_W-1:0]        leak_q;
    logic [WEIGHT_W-1:0]      w_q   [N_NEURONS][N_IN];
    logic signed [MEM_W-1:0]  mem_q [N_NEURONS];

    logic [WEIGHT_W-1:0]      w_row [N_IN];
    logic signed [MEM_W-1:0]  mem_nxt;
    logic                     fire;
    logic                     step_go;
    logic                     unused_cfg;

    assign step_go       = (state_q == IDLE) && en_i && step_i;
    // A start request outranks a config write in the same cycle.
    assign cfg.cfg_ready = (state_q == IDLE) && !(en_i && step_i);
    assign unused_cfg    = ^cfg.cfg_data;

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            w_row[IN_W'(i)] = w_q[idx_q][IN_W'(i)];
        end
    end

    always_comb begin
        spk_d        = spk_q;
        spk_d[idx_q] = fire;
    end

    snn_lif_update #(
        .N_IN     (N_IN),
        .WEIGHT_W (WEIGHT_W),
        .MEM_W    (MEM_W),
        .LEAK_W   (LEAK_W)
    ) u_update (
        .weights_i (w_row),
        .spikes_i  (in_q),
        .mem_i     (mem_q[idx_q]),
        .thresh_i  (thresh_q),
        .leak_i    (leak_q),
        .mem_o     (mem_nxt),
        .fire_o    (fire)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            in_q      <= '0;
            spk_q     <= '0;
            out_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            thresh_q  <= THRESH_RST32[MEM_W-2:0];
            leak_q    <= LEAK_RST32[LEAK_W-1:0];
            for (int n = 0; n < N_NEURONS; n++) begin
                mem_q[IDX_W'(n)] <= '0;
                for (int i = 0; i < N_IN; i++) begin
                    w_q[IDX_W'(n)][IN_W'(i)] <= '0;
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (step_go) begin
                        state_q <= EVAL;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        in_q    <= in_spikes_i;
                        spk_q   <= '0;
                    end else if (cfg.cfg_valid) begin
                        for (int n = 0; n < N_NEURONS; n++) begin
                            for (int i = 0; i < N_IN; i++) begin
                                if (cfg.cfg_addr == ADDR_W'(n * N_IN + i)) begin
                                    w_q[IDX_W'(n)][IN_W'(i)] <= cfg.cfg_data[WEIGHT_W-1:0];
                                end
                            end
                        end
                        if (cfg.cfg_addr == ADDR_W'(addr_thresh(N_W))) begin
                            thresh_q <= cfg.cfg_data[MEM_W-2:0];
                        end
                        if (cfg.cfg_addr == ADDR_W'(addr_leak(N_W))) begin
                            leak_q <= cfg.cfg_data[LEAK_W-1:0];
                        end
                        if (cfg.cfg_addr == ADDR_W'(addr_clear(N_W))) begin
                            overrun_q <= 1'b0;
                            for (int n = 0; n < N_NEURONS; n++) begin
                                mem_q[IDX_W'(n)] <= '0;
                            end
                        end
                    end
                end
                EVAL: begin
                    mem_q[idx_q] <= mem_nxt;
                    spk_q        <= spk_d;
                    if (step_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (idx_q == IDX_W'(N_NEURONS - 1)) begin
                        state_q <= DONE;
                        out_q   <= spk_d;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (step_i) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign out_spikes_o = out_q;
    assign overrun_o    = overrun_q;
    assign mem_dbg_o    = mem_q[dbg_sel_i];

endmodule
